// File: rtl/dc_removal_if.sv
// Sample-stream bundle between the ADC front end and the DC-removal block.
// The master side drives ADC samples. The slave side (dc_removal) returns corrected samples and status.
interface dc_removal_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  adc_valid;
  logic [DATA_WIDTH-1:0] adc_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic                  en;
  logic [DATA_WIDTH-1:0] dc_level;

  modport master (
    output adc_valid, adc_data,
    input  data_out, out_valid, en, dc_level
  );

  modport slave (
    input  adc_valid, adc_data,
    output data_out, out_valid, en, dc_level
  );
endinterface

// File: rtl/dc_removal.sv
// DC removal: averages 2^AVG_LOG2-sample windows into dc_level and subtracts it with saturation.
// Define DC_REMOVAL_TRACK_EN to refresh dc_level every window; otherwise it freezes after calibration.
module dc_removal #(
  parameter int DATA_WIDTH = 12,
  parameter int AVG_LOG2   = 8
) (
  input  logic        clk,
  input  logic        rst,
  dc_removal_if.slave bus
);

  localparam int AccW = DATA_WIDTH + AVG_LOG2;
  localparam logic [DATA_WIDTH-1:0] SatMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SatMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

`ifdef DC_REMOVAL_TRACK_EN
  localparam bit TrackEn = 1'b1;
`else
  localparam bit TrackEn = 1'b0;
`endif

  typedef enum logic {CAL, RUN} state_e;

  state_e                 state_q;
  logic [AccW-1:0]        acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  dc_level_q, dc_level_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   out_valid_q, en_q;
  logic                   wrap;
  logic signed [DATA_WIDTH:0] diff;

  assign acc_sum = acc_q + AccW'(bus.adc_data);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    dc_level_d = dc_level_q;
    data_out_d = data_out_q;
    wrap       = bus.adc_valid && (cnt_q == '1);
    diff       = $signed({1'b0, bus.adc_data}) - $signed({1'b0, dc_level_q});

    if (bus.adc_valid) begin
      cnt_d = cnt_q + 1'b1;
      // The wrap sample is part of the closing window; the next window starts empty.
      acc_d = wrap ? '0 : acc_sum;
    end

    if (wrap && (TrackEn || state_q == CAL)) begin
      dc_level_d = acc_sum[AccW-1:AVG_LOG2];
    end

    // The subtraction uses the pre-update dc_level, so a wrap sample sees the old estimate.
    if (bus.adc_valid && state_q == RUN) begin
      if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
        data_out_d = diff[DATA_WIDTH] ? SatMin : SatMax;
      end else begin
        data_out_d = diff[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= CAL;
      acc_q       <= '0;
      cnt_q       <= '0;
      dc_level_q  <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dc_level_q  <= dc_level_d;
      data_out_q  <= data_out_d;
      out_valid_q <= bus.adc_valid && (state_q == RUN);
      case (state_q)
        CAL: if (wrap) begin
          state_q <= RUN;
          en_q    <= 1'b1;
        end
        RUN: state_q <= RUN;
        default: state_q <= CAL;
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.en        = en_q;
  assign bus.dc_level  = dc_level_q;

endmodule
